nmr_scan_scheduler: RTL and testbench
=====================================

Name: nmr_scan_scheduler

Overview:
- Multi-scan sequencer above the NMR acquisition FSM: re-arms, starts and collects N consecutive excitation/acquisition scans, inserting a programmable repetition delay (TR) between them.
- Drives the acquisition FSM's soft reset and start inputs, watches its done flag, and provides a 4-step phase-cycling index for the generator.
- Reports progress, done and timeout status to the PS status register.

Parameters:
- CNT_W, 32, width of TR and timeout counters.
- SCAN_W, 16, width of scan count/index.
- ARM_CYCLES, 4, cycles the acquisition FSM is held in reset before each scan (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a scan series.
- abort  in  1  one-cycle pulse; stops the series immediately.
- cfg_nb_scans  in  SCAN_W  number of scans; 0 = none.
- cfg_tr_cycles  in  CNT_W  recovery delay between scans, in clk cycles.
- cfg_timeout  in  CNT_W  max cycles waiting for acq_done per scan; 0 = disabled.
- cfg_phase_en  in  1  enables phase cycling.
- acq_done  in  1  level done flag from the acquisition FSM (sticky until it is reset).
- acq_soft_rst_n  out  1  soft reset to the acquisition FSM, active low.
- acq_start  out  1  start level to the acquisition FSM.
- phase_sel  out  2  phase-cycle index for the generator.
- scan_idx  out  SCAN_W  index of the current scan; count of completed scans once done.
- scan_done  out  1  one-cycle pulse per completed scan, for the readout/DMA trigger.
- busy  out  1  series in progress.
- done  out  1  sticky; series finished.
- error  out  1  sticky; timeout occurred.
- sts  out  32  {error, done, busy, 13'b0, scan_idx} packed in bits [31:29] and [15:0], where SCAN_W=16.

Behaviour:
- Reset (rst=1 at clk edge):
  - State becomes IDLE; all counters are cleared.
  - All outputs are 0, including acq_soft_rst_n. The acquisition FSM is held in reset.
- Config latching: cfg_* are sampled on the accepted start and held for the whole series. Later cfg changes do not affect a running series.
- States:
  - IDLE: acq_soft_rst_n=0, acq_start=0, busy=0.
    - start with cfg_nb_scans=0 -> DONE; done=1 and scan_done stays 0.
    - start otherwise -> ARM; done and error are cleared and scan_idx is set to 0.
  - ARM: acq_soft_rst_n=0 for exactly ARM_CYCLES cycles, busy=1, then -> RUN.
  - RUN: acq_soft_rst_n=1, acq_start=1, and the timeout counter increments each cycle from 0.
    - acq_done=1 -> scan_done pulses for 1 cycle and scan_idx increments.
    - If the new scan_idx equals nb_scans -> DONE; otherwise -> RECOVER.
    - If cfg_timeout!=0 and the counter reaches cfg_timeout-1 without acq_done -> ERR.
    - If acq_done and the timeout expire in the same cycle, acq_done wins.
  - RECOVER: acq_soft_rst_n=1, acq_start=0, busy=1. Lasts max(cfg_tr_cycles,1) cycles, then -> ARM.
  - DONE: done=1, busy=0, acq_soft_rst_n=0. A start restarts the series, with the same rules as in IDLE.
  - ERR: error=1, busy=0, acq_soft_rst_n=0. A start restarts the series.
- abort: from any state -> IDLE on the next cycle. busy drops, done and error are not set, and scan_idx holds its value. If abort and start arrive in the same cycle, abort wins.
- start while busy: ignored.
- Latency: start to first acq_start=1 is exactly 1+ARM_CYCLES cycles.
- scan_done: asserted in the cycle after acq_done is sampled in RUN. It fires once per scan even though acq_done is a level.
- phase_sel = cfg_phase_en ? scan_idx[1:0] : 2'b00. It is updated together with scan_idx and wraps 3->0.
- Arithmetic:
  - scan_idx never exceeds nb_scans; the comparison is full SCAN_W width with no wrap.
  - Counters are unsigned CNT_W and saturate rather than wrap.

Decomposition:
- Package nmr_seq_pkg holds:
  - State encodings IDLE/ARM/RUN/RECOVER/DONE/ERR (3-bit).
  - sts bit positions: STS_ERR=31, STS_DONE=30, STS_BUSY=29, STS_IDX_LSB=0.
- Sub-module nmr_seq_timer: loadable CNT_W up-counter with load, enable, and an expire compare. One instance is shared by the ARM, RECOVER and RUN-timeout phases, since they are mutually exclusive.

Test Plan:
- Three-scan series: nb_scans=3, tr=10, timeout=0; acq_done model asserts 50 cycles after acq_start -> three scan_done pulses, each RECOVER lasts 10 cycles, then done=1, scan_idx=3, sts=0x4000_0003.
- Zero scans: nb_scans=0, start -> done=1 on the next cycle, no acq_start, no scan_done, busy stays 0.
- Timeout: nb_scans=2, timeout=100, acq_done never asserted -> ERR 100 cycles after acq_start rises; error=1, scan_idx=0, acq_soft_rst_n=0.
- Abort mid-series: nb_scans=5, abort during scan 2 RUN -> next cycle IDLE, busy=0, done=0, scan_idx=2; a later start re-runs from scan_idx=0.
- Phase cycling: phase_en=1, nb_scans=6 -> phase_sel sequence 0,1,2,3,0,1; with phase_en=0 it stays 0.
- Corner cases:
  - acq_done held high for 20 cycles yields only one scan_done.
  - acq_done coinciding with the timeout expiry -> counted as success.
  - start during RUN is ignored.
  - rst mid-RECOVER -> all outputs 0 next cycle.

Source files
------------

// File: rtl/nmr_seq_pkg.sv
// nmr_seq_pkg
// Shared definitions for the NMR multi-scan scheduler:
//   - seq_state_e : scheduler state encoding (3 bits)
//   - STS_*       : bit positions inside the 32-bit PS status word
//   - is_active() : true for the states that make up a running series
package nmr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    RUN     = 3'd2,
    RECOVER = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } seq_state_e;

  localparam int STS_ERR     = 31;
  localparam int STS_DONE    = 30;
  localparam int STS_BUSY    = 29;
  localparam int STS_IDX_LSB = 0;

  // ARM, RUN and RECOVER together form a series in progress.
  function automatic logic is_active(seq_state_e s);
    return (s == ARM) || (s == RUN) || (s == RECOVER);
  endfunction

endpackage

// File: rtl/nmr_seq_timer.sv
// nmr_seq_timer
// Loadable saturating up-counter with an equality compare. The scheduler
// shares one instance between the ARM hold, the RECOVER delay and the
// RUN timeout, since only one of those phases is ever active.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   load_i   in   clear the count to 0 (wins over en_i)
//   en_i     in   increment the count (saturates at all-ones)
//   cmp_i    in   compare value
//   expire_o out  count currently equals cmp_i
module nmr_seq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cmp_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: load clears, enable counts up but never wraps past all-ones.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == cmp_i);

endmodule

// File: rtl/nmr_scan_scheduler.sv
// nmr_scan_scheduler
// Multi-scan sequencer sitting above the NMR acquisition FSM. For each of
// nb_scans scans it holds the acquisition FSM in soft reset for ARM_CYCLES,
// starts it, waits for its done flag (with optional timeout), then waits
// the repetition delay before re-arming.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, abort      one-cycle control pulses (abort wins)
//   cfg_nb_scans      number of scans (0 = none), latched on start
//   cfg_tr_cycles     recovery delay between scans, latched on start
//   cfg_timeout       per-scan acq_done timeout (0 = disabled), latched
//   cfg_phase_en      enables phase cycling, latched
//   acq_done          sticky done level from the acquisition FSM
//   acq_soft_rst_n    active-low soft reset to the acquisition FSM
//   acq_start         start level to the acquisition FSM
//   phase_sel         phase-cycle index for the generator
//   scan_idx          current scan index / completed scan count
//   scan_done         one-cycle pulse per completed scan
//   busy, done, error series status (done and error are sticky)
//   sts               {error, done, busy, 13'b0, scan_idx}
module nmr_scan_scheduler
  import nmr_seq_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int SCAN_W     = 16,
  parameter int ARM_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [SCAN_W-1:0] cfg_nb_scans,
  input  logic [CNT_W-1:0]  cfg_tr_cycles,
  input  logic [CNT_W-1:0]  cfg_timeout,
  input  logic              cfg_phase_en,
  input  logic              acq_done,
  output logic              acq_soft_rst_n,
  output logic              acq_start,
  output logic [1:0]        phase_sel,
  output logic [SCAN_W-1:0] scan_idx,
  output logic              scan_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       sts
);

  seq_state_e state_q, state_d;

  logic [SCAN_W-1:0] scan_idx_q, scan_idx_d;
  logic              scan_done_q, scan_done_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  // Configuration snapshot taken on the accepted start.
  logic [SCAN_W-1:0] nb_q, nb_d;
  logic [CNT_W-1:0]  tr_q, tr_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic              phase_en_q, phase_en_d;

  logic             timer_load;
  logic             timer_en;
  logic [CNT_W-1:0] timer_cmp;
  logic             timer_expire;

  // One extra bit so the "last scan" compare can never wrap.
  logic [SCAN_W:0] idx_inc;

  assign idx_inc = {1'b0, scan_idx_q} + 1'b1;

  // Compare value for the shared timer, chosen by the phase it is timing.
  // Each value is "length - 1" because the count starts at 0 on entry.
  always_comb begin
    timer_cmp = '0;
    case (state_q)
      ARM:     timer_cmp = CNT_W'(ARM_CYCLES - 1);
      RUN:     timer_cmp = tmo_q - 1'b1;
      RECOVER: timer_cmp = (tr_q == '0) ? '0 : (tr_q - 1'b1);
      default: timer_cmp = '0;
    endcase
  end

  // Next-state logic. Abort dominates everything; a start is only honoured
  // when no series is running. In RUN, acq_done is checked before the
  // timeout so a simultaneous done/expiry counts as a successful scan.
  always_comb begin
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    scan_done_d = 1'b0;
    done_d      = done_q;
    error_d     = error_q;
    nb_d        = nb_q;
    tr_d        = tr_q;
    tmo_d       = tmo_q;
    phase_en_d  = phase_en_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            nb_d       = cfg_nb_scans;
            tr_d       = cfg_tr_cycles;
            tmo_d      = cfg_timeout;
            phase_en_d = cfg_phase_en;
            error_d    = 1'b0;
            scan_idx_d = '0;
            if (cfg_nb_scans == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ARM;
              done_d  = 1'b0;
            end
          end
        end
        ARM: begin
          if (timer_expire) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (acq_done) begin
            scan_done_d = 1'b1;
            scan_idx_d  = idx_inc[SCAN_W-1:0];
            if (idx_inc >= {1'b0, nb_q}) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RECOVER;
            end
          end else if ((tmo_q != '0) && timer_expire) begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
        RECOVER: begin
          if (timer_expire) begin
            state_d = ARM;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The timer restarts from 0 on every state change and counts only while
  // a series is active, so each timed phase measures from its own entry.
  assign timer_load = (state_d != state_q);
  assign timer_en   = is_active(state_q);

  nmr_seq_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (timer_load),
    .en_i    (timer_en),
    .cmp_i   (timer_cmp),
    .expire_o(timer_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      scan_idx_q  <= '0;
      scan_done_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      nb_q        <= '0;
      tr_q        <= '0;
      tmo_q       <= '0;
      phase_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      scan_done_q <= scan_done_d;
      done_q      <= done_d;
      error_q     <= error_d;
      nb_q        <= nb_d;
      tr_q        <= tr_d;
      tmo_q       <= tmo_d;
      phase_en_q  <= phase_en_d;
    end
  end

  // The acquisition FSM only leaves reset while scanning or recovering;
  // keeping it out of reset in RECOVER lets it finish its own wind-down.
  assign acq_soft_rst_n = (state_q == RUN) || (state_q == RECOVER);
  assign acq_start      = (state_q == RUN);
  assign busy           = is_active(state_q);
  assign done           = done_q;
  assign error          = error_q;
  assign scan_done      = scan_done_q;
  assign scan_idx       = scan_idx_q;
  assign phase_sel      = phase_en_q ? scan_idx_q[1:0] : 2'b00;

  always_comb begin
    sts                              = '0;
    sts[STS_ERR]                     = error_q;
    sts[STS_DONE]                    = done_q;
    sts[STS_BUSY]                    = busy;
    sts[STS_IDX_LSB +: SCAN_W]       = scan_idx_q;
  end

endmodule

// File: tb/tb_nmr_scan_scheduler.sv
// tb_nmr_scan_scheduler
// Self-checking bench for nmr_scan_scheduler. A behavioural model of the
// series (phase + countdown) predicts every output each cycle; directed
// scenarios add hand-computed expectations, followed by randomized traffic.
module tb_nmr_scan_scheduler;

  localparam int CNT_W      = 32;
  localparam int SCAN_W     = 16;
  localparam int ARM_CYCLES = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [SCAN_W-1:0] cfg_nb_scans;
  logic [CNT_W-1:0]  cfg_tr_cycles;
  logic [CNT_W-1:0]  cfg_timeout;
  logic              cfg_phase_en;
  logic              acq_done;
  logic              acq_soft_rst_n;
  logic              acq_start;
  logic [1:0]        phase_sel;
  logic [SCAN_W-1:0] scan_idx;
  logic              scan_done;
  logic              busy;
  logic              done;
  logic              error;
  logic [31:0]       sts;

  int testCount = 0;
  int failCount = 0;

  nmr_scan_scheduler #(
    .CNT_W(CNT_W), .SCAN_W(SCAN_W), .ARM_CYCLES(ARM_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_nb_scans(cfg_nb_scans), .cfg_tr_cycles(cfg_tr_cycles),
    .cfg_timeout(cfg_timeout), .cfg_phase_en(cfg_phase_en),
    .acq_done(acq_done), .acq_soft_rst_n(acq_soft_rst_n),
    .acq_start(acq_start), .phase_sel(phase_sel), .scan_idx(scan_idx),
    .scan_done(scan_done), .busy(busy), .done(done), .error(error),
    .sts(sts)
  );

  always #5 clk = ~clk;

  // Behavioural model: which phase of the series we are in and how many
  // cycles remain in it.
  localparam logic [2:0] MD_IDLE = 3'd0, MD_DONE = 3'd1, MD_ERR = 3'd2,
                         MD_ARM  = 3'd3, MD_RUN  = 3'd4, MD_REC = 3'd5;

  typedef struct packed {
    logic [2:0]  mode;
    logic [31:0] left;
    logic [31:0] runCnt;
    logic [15:0] idx;
    logic        done;
    logic        err;
    logic        sdone;
    logic [15:0] nb;
    logic [31:0] tr;
    logic [31:0] tmo;
    logic        pen;
  } model_t;

  model_t m = '0;

  function automatic model_t modelStep(model_t c, logic r, logic s, logic a,
                                       logic ad, logic [15:0] nb,
                                       logic [31:0] tr, logic [31:0] tmo,
                                       logic pen);
    model_t n = c;
    n.sdone = 1'b0;
    if (r) begin
      n = '0;
    end else if (a) begin
      n.mode = MD_IDLE;
    end else if (c.mode == MD_IDLE || c.mode == MD_DONE || c.mode == MD_ERR) begin
      if (s) begin
        n.nb = nb; n.tr = tr; n.tmo = tmo; n.pen = pen;
        n.err = 1'b0; n.idx = '0;
        if (nb == 0) begin
          n.mode = MD_DONE; n.done = 1'b1;
        end else begin
          n.mode = MD_ARM; n.done = 1'b0; n.left = ARM_CYCLES;
        end
      end
    end else if (c.mode == MD_ARM) begin
      n.left = c.left - 1;
      if (n.left == 0) begin
        n.mode = MD_RUN; n.runCnt = 0;
      end
    end else if (c.mode == MD_RUN) begin
      if (ad) begin
        n.idx = c.idx + 16'd1;
        n.sdone = 1'b1;
        if (n.idx == c.nb) begin
          n.mode = MD_DONE; n.done = 1'b1;
        end else begin
          n.mode = MD_REC; n.left = (c.tr == 0) ? 32'd1 : c.tr;
        end
      end else if (c.tmo != 0 && c.runCnt == c.tmo - 1) begin
        n.mode = MD_ERR; n.err = 1'b1;
      end else begin
        n.runCnt = c.runCnt + 1;
      end
    end else if (c.mode == MD_REC) begin
      n.left = c.left - 1;
      if (n.left == 0) begin
        n.mode = MD_ARM; n.left = ARM_CYCLES;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= modelStep(m, rst, start, abort, acq_done, cfg_nb_scans,
                   cfg_tr_cycles, cfg_timeout, cfg_phase_en);
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Acquisition FSM stand-in: raises acq_done acqLat cycles after acq_start
  // goes high (0 = never) and keeps it until soft reset.
  int acqLat = 0;
  int acqCnt = 0;

  // Monitors used by the directed expectations.
  int cyc = 0, riseCyc = 0, errCyc = 0, riseN = 0, sdCnt = 0;
  int recCur = 0, recN = 0;
  logic prevStart = 1'b0, prevErr = 1'b0;
  logic [1:0] phaseArr [256];
  int recArr [64];
  bit chkEn = 1'b0;

  always @(negedge clk) begin
    if (chkEn) begin
      logic expBusy;
      expBusy = (m.mode == MD_ARM) || (m.mode == MD_RUN) || (m.mode == MD_REC);
      checkOutput("acq_soft_rst_n", 32'(acq_soft_rst_n), 32'((m.mode == MD_RUN) || (m.mode == MD_REC)));
      checkOutput("acq_start", 32'(acq_start), 32'(m.mode == MD_RUN));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("done", 32'(done), 32'(m.done));
      checkOutput("error", 32'(error), 32'(m.err));
      checkOutput("scan_done", 32'(scan_done), 32'(m.sdone));
      checkOutput("scan_idx", 32'(scan_idx), 32'(m.idx));
      checkOutput("phase_sel", 32'(phase_sel), 32'(m.pen ? m.idx[1:0] : 2'b00));
      checkOutput("sts", sts, {m.err, m.done, expBusy, 13'b0, m.idx});
    end
    if (!acq_soft_rst_n) begin
      acqCnt   <= 0;
      acq_done <= 1'b0;
    end else if (acq_start) begin
      acqCnt <= acqCnt + 1;
      if (acqLat != 0 && acqCnt + 1 >= acqLat) acq_done <= 1'b1;
    end
    cyc   <= cyc + 1;
    sdCnt <= sdCnt + int'(scan_done);
    prevStart <= acq_start;
    prevErr   <= error;
    if (acq_start && !prevStart) begin
      riseCyc <= cyc + 1;
      phaseArr[riseN[7:0]] <= phase_sel;
      riseN <= riseN + 1;
    end
    if (error && !prevErr) errCyc <= cyc + 1;
    if (busy && acq_soft_rst_n && !acq_start) begin
      recCur <= recCur + 1;
    end else if (recCur != 0) begin
      recArr[recN[5:0]] <= recCur;
      recN   <= recN + 1;
      recCur <= 0;
    end
  end

  int startCyc = 0;

  task automatic applyStimulus(input logic [15:0] nb, input logic [31:0] tr,
                               input logic [31:0] tmo, input logic pen,
                               input int lat);
    @(negedge clk);
    cfg_nb_scans  = nb;
    cfg_tr_cycles = tr;
    cfg_timeout   = tmo;
    cfg_phase_en  = pen;
    acqLat        = lat;
    start         = 1'b1;
    #1 startCyc = cyc;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  // Bounded wait: 0 = series ended, 1 = third scan running,
  // 2 = in recovery, 3 = acq_start high.
  task automatic waitUntil(input int what, input int bound);
    bit hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk); #1;
      case (what)
        0:       hit = !busy && (done || error);
        1:       hit = acq_start && (scan_idx == 16'd2);
        2:       hit = busy && acq_soft_rst_n && !acq_start;
        default: hit = acq_start;
      endcase
    end
    testCount++;
    if (!hit) begin
      failCount++;
      $display("[TB] FAIL wait_%0d: condition not reached within %0d cycles", what, bound);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sd0, r0, rec0, r;
    logic [1:0] phOr;
    int expPh [6] = '{0, 1, 2, 3, 0, 1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; acq_done = 1'b0;
    cfg_nb_scans = '0; cfg_tr_cycles = '0; cfg_timeout = '0; cfg_phase_en = 1'b0;
    chkEn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_sts", sts, 32'h0);
    checkOutput("reset_soft_rst_n", 32'(acq_soft_rst_n), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Three scans, 10-cycle recovery, done latency 50.
    sd0 = sdCnt; rec0 = recN;
    applyStimulus(16'd3, 32'd10, 32'd0, 1'b0, 50);
    waitUntil(3, 20);
    checkOutput("start_latency", 32'(riseCyc - startCyc), 32'(1 + ARM_CYCLES));
    waitUntil(0, 1000);
    checkOutput("three_sts", sts, 32'h4000_0003);
    checkOutput("three_scan_done_cnt", 32'(sdCnt - sd0), 32'd3);
    checkOutput("three_recover_cnt", 32'(recN - rec0), 32'd2);
    checkOutput("three_recover_len0", 32'(recArr[rec0[5:0]]), 32'd10);
    checkOutput("three_recover_len1", 32'(recArr[6'(rec0 + 1)]), 32'd10);

    // Timeout with acq_done never asserted.
    applyStimulus(16'd2, 32'd5, 32'd100, 1'b0, 0);
    waitUntil(0, 400);
    checkOutput("timeout_cycles", 32'(errCyc - riseCyc), 32'd100);
    checkOutput("timeout_error", 32'(error), 32'd1);
    checkOutput("timeout_idx", 32'(scan_idx), 32'd0);
    checkOutput("timeout_soft_rst_n", 32'(acq_soft_rst_n), 32'd0);

    // Zero scans.
    sd0 = sdCnt; r0 = riseN;
    applyStimulus(16'd0, 32'd5, 32'd0, 1'b0, 5);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_error", 32'(error), 32'd0);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("zero_no_scan_done", 32'(sdCnt - sd0), 32'd0);
    checkOutput("zero_no_acq_start", 32'(riseN - r0), 32'd0);

    // Abort during the third scan (index 2) RUN.
    applyStimulus(16'd5, 32'd3, 32'd0, 1'b0, 20);
    waitUntil(1, 500);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_idx", 32'(scan_idx), 32'd2);
    applyStimulus(16'd5, 32'd3, 32'd0, 1'b0, 10);
    checkOutput("rerun_idx", 32'(scan_idx), 32'd0);
    waitUntil(0, 1000);
    checkOutput("rerun_sts", sts, 32'h4000_0005);

    // Phase cycling on, then off.
    r0 = riseN;
    applyStimulus(16'd6, 32'd2, 32'd0, 1'b1, 8);
    waitUntil(0, 1000);
    checkOutput("phase_rises", 32'(riseN - r0), 32'd6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("phase_seq%0d", i), 32'(phaseArr[8'(r0 + i)]), 32'(expPh[i]));
    r0 = riseN;
    applyStimulus(16'd6, 32'd2, 32'd0, 1'b0, 8);
    waitUntil(0, 1000);
    phOr = 2'b00;
    for (int i = 0; i < 6; i++) phOr = phOr | phaseArr[8'(r0 + i)];
    checkOutput("phase_off", 32'(phOr), 32'd0);

    // acq_done held through a 20-cycle recovery: one pulse per scan.
    sd0 = sdCnt;
    applyStimulus(16'd2, 32'd20, 32'd0, 1'b0, 10);
    waitUntil(0, 500);
    checkOutput("held_scan_done_cnt", 32'(sdCnt - sd0), 32'd2);

    // acq_done arrives in the same cycle the timeout expires.
    applyStimulus(16'd1, 32'd5, 32'd30, 1'b0, 30);
    waitUntil(0, 200);
    checkOutput("coincide_done", 32'(done), 32'd1);
    checkOutput("coincide_error", 32'(error), 32'd0);

    // start during RUN with different config is ignored.
    applyStimulus(16'd2, 32'd3, 32'd0, 1'b0, 20);
    waitUntil(3, 20);
    @(negedge clk); start = 1'b1; cfg_nb_scans = 16'd1;
    @(negedge clk); start = 1'b0;
    waitUntil(0, 500);
    checkOutput("ignored_start_idx", 32'(scan_idx), 32'd2);

    // Reset in the middle of RECOVER.
    applyStimulus(16'd3, 32'd30, 32'd0, 1'b1, 5);
    waitUntil(2, 200);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    checkOutput("rst_sts", sts, 32'h0);
    checkOutput("rst_soft_rst_n", 32'(acq_soft_rst_n), 32'd0);
    checkOutput("rst_acq_start", 32'(acq_start), 32'd0);
    checkOutput("rst_phase", 32'(phase_sel), 32'd0);

    // Randomized traffic, checked by the model every cycle.
    for (int it = 0; it < 30; it++) begin
      applyStimulus(16'($urandom_range(0, 4)), $urandom_range(0, 6),
                    ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom_range(10, 60),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 50)));
      repeat ($urandom_range(60, 400)) begin
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        r = int'($urandom_range(0, 199));
        if (r < 2) begin
          abort = 1'b1;
        end else if (r < 5) begin
          start        = 1'b1;
          cfg_nb_scans = 16'($urandom_range(0, 4));
          cfg_phase_en = 1'($urandom_range(0, 1));
        end else if (r == 5) begin
          rst = 1'b1;
        end else if (r < 12) begin
          cfg_tr_cycles = $urandom_range(0, 6);
          cfg_timeout   = $urandom_range(0, 40);
        end
      end
      @(negedge clk);
      start = 1'b0; abort = 1'b0; rst = 1'b0;
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
